// File: rtl/hsstl_rst4mcrsw_lane_rate_sched_v1_0_if.sv
// Lane rate scheduler bus.
// Purpose : groups the scheduler's lane-facing signals so that the scheduler and
//           its environment connect through one port.
// Signals : pll_ready  shared PLL locked
//           req_rate   requested rate per lane (1 = gen2, 0 = gen1)
//           lane_fsm   4-bit TX reset FSM state per lane, lane i = [4i+3:4i]
//           lane_rate  rate driven to each lane FSM
//           grant      one-hot lane currently being rate-changed
//           busy       scheduler not idle
//           err_flag   sticky per-lane timeout flag
// Modports: slave  = scheduler side, master = lane/environment side.
`timescale 1ns/1ps
interface hsstl_rst4mcrsw_lane_rate_sched_v1_0_if #(
    parameter int unsigned LANE_NUM = 4
);
    logic                      pll_ready;
    logic [LANE_NUM-1:0]       req_rate;
    logic [4*LANE_NUM-1:0]     lane_fsm;
    logic [LANE_NUM-1:0]       lane_rate;
    logic [LANE_NUM-1:0]       grant;
    logic                      busy;
    logic [LANE_NUM-1:0]       err_flag;

    modport master (
        output pll_ready, req_rate, lane_fsm,
        input  lane_rate, grant, busy, err_flag
    );

    modport slave (
        input  pll_ready, req_rate, lane_fsm,
        output lane_rate, grant, busy, err_flag
    );
endinterface

// File: rtl/hsstl_rst4mcrsw_lane_rate_sched_v1_0.sv
// Lane rate-change scheduler for HSST TX reset FSMs sharing one PLL.
// Purpose : grants one lane at a time (round robin) to apply a rate change, then
//           watches that lane's FSM enter TX_RATE_ONLY and return to TX_RST_DONE,
//           flagging lanes that do not start or finish in bounded time.
// Ports   : clk  clock (lane FSM domain)
//           rst  synchronous active-high reset
//           bus  slave side of the scheduler interface (see _if file)
`timescale 1ns/1ps
module hsstl_rst4mcrsw_lane_rate_sched_v1_0 #(
    parameter int unsigned LANE_NUM      = 4,
    parameter int unsigned START_TIMEOUT = 15,
    parameter int unsigned DONE_TIMEOUT  = 1023,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNTR_WIDTH    = 10
) (
    input logic clk,
    input logic rst,
    hsstl_rst4mcrsw_lane_rate_sched_v1_0_if.slave bus
);
    localparam int unsigned IdxW         = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1;
    localparam logic [3:0]  FsmTxRstDone = 4'd7;
    localparam logic [3:0]  FsmTxRateOnly = 4'd8;

    typedef enum logic [2:0] {
        StIdle, StArb, StApply, StWaitStart, StWaitDone, StSettle
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [LANE_NUM-1:0]   r_lane_rate;
    logic [LANE_NUM-1:0]   r_grant;
    logic [LANE_NUM-1:0]   r_err_flag;
    logic [CNTR_WIDTH-1:0] r_cntr;
    logic [IdxW-1:0]       r_rr_ptr;
    logic [IdxW-1:0]       r_gidx;      // index form of r_grant

    logic [LANE_NUM-1:0]   w_pending;
    logic                  w_sel_found;
    logic [IdxW-1:0]       w_sel_idx;
    logic [LANE_NUM-1:0]   w_sel_onehot;
    logic [3:0]            w_lane_state;
    logic                  w_abort;
    logic                  w_start_to;
    logic                  w_done_to;
    logic                  w_settle_end;
    logic                  w_busy;

    assign w_pending    = bus.req_rate ^ r_lane_rate;
    assign w_lane_state = bus.lane_fsm[4*r_gidx +: 4];
    assign w_abort      = (r_state != StIdle) && !bus.pll_ready;
    assign w_start_to   = (r_cntr == CNTR_WIDTH'(START_TIMEOUT));
    assign w_done_to    = (r_cntr == CNTR_WIDTH'(DONE_TIMEOUT));
    assign w_settle_end = (r_cntr == CNTR_WIDTH'(SETTLE_CYCLES));

    // Round-robin pick: scan downwards so the lane closest to r_rr_ptr wins last.
    always_comb begin
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        w_sel_onehot = '0;
        for (int k = int'(LANE_NUM) - 1; k >= 0; k--) begin
            if (w_pending[(int'(r_rr_ptr) + k) % int'(LANE_NUM)]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IdxW'((int'(r_rr_ptr) + k) % int'(LANE_NUM));
            end
        end
        w_sel_onehot[w_sel_idx] = 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a lost PLL lock abandons whatever is in progress.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = StIdle;
        end else begin
            unique case (r_state)
                StIdle:      if (bus.pll_ready && (|w_pending)) w_state_nxt = StArb;
                StArb:       w_state_nxt = w_sel_found ? StApply : StIdle;
                StApply:     w_state_nxt = StWaitStart;
                StWaitStart: begin
                    if (w_lane_state == FsmTxRateOnly) w_state_nxt = StWaitDone;
                    else if (w_start_to)               w_state_nxt = StSettle;
                end
                StWaitDone:  if ((w_lane_state == FsmTxRstDone) || w_done_to) w_state_nxt = StSettle;
                StSettle:    if (w_settle_end) w_state_nxt = StIdle;
                default:     w_state_nxt = StIdle;
            endcase
        end
    end

    // Output logic
    always_comb begin
        w_busy = (r_state != StIdle);
    end

    // Datapath registers tied to the current state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_rate <= '0;
            r_grant     <= '0;
            r_err_flag  <= '0;
            r_cntr      <= '0;
            r_rr_ptr    <= '0;
            r_gidx      <= '0;
        end else if (w_abort) begin
            r_grant <= '0;
            r_cntr  <= '0;
        end else begin
            case (r_state)
                StArb: begin
                    if (w_sel_found) begin
                        r_grant <= w_sel_onehot;
                        r_gidx  <= w_sel_idx;
                    end
                end
                StApply: begin
                    r_lane_rate[r_gidx] <= bus.req_rate[r_gidx];
                    r_cntr              <= '0;
                end
                StWaitStart: begin
                    if (w_lane_state == FsmTxRateOnly) begin
                        r_cntr <= '0;
                    end else if (w_start_to) begin
                        r_err_flag[r_gidx] <= 1'b1;
                        r_cntr             <= '0;
                    end else begin
                        r_cntr <= r_cntr + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (w_lane_state == FsmTxRstDone) begin
                        r_cntr <= '0;
                    end else if (w_done_to) begin
                        r_err_flag[r_gidx] <= 1'b1;
                        r_cntr             <= '0;
                    end else begin
                        r_cntr <= r_cntr + 1'b1;
                    end
                end
                StSettle: begin
                    if (w_settle_end) begin
                        r_grant  <= '0;
                        r_rr_ptr <= (r_gidx == IdxW'(LANE_NUM - 1)) ? '0 : r_gidx + 1'b1;
                    end else begin
                        r_cntr <= r_cntr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.lane_rate = r_lane_rate;
    assign bus.grant     = r_grant;
    assign bus.busy      = w_busy;
    assign bus.err_flag  = r_err_flag;
endmodule
